// File: rtl/button_capture_pkg.sv
// relaxar_pkg: colour and capture-FSM types shared by the button capture front end.
package relaxar_pkg;
    typedef enum logic [1:0] {GREEN = 2'd0, RED = 2'd1, YELLOW = 2'd2, BLUE = 2'd3} color_t;
    typedef enum logic [1:0] {WAIT_REL, ARMED, FIRE, HOLD} cap_state_t;
    function automatic color_t encode(input logic [3:0] onehot);
        return onehot[3] ? BLUE : onehot[2] ? YELLOW : onehot[1] ? RED : GREEN;
    endfunction
endpackage

// File: rtl/button_capture_if.sv
// button_capture_if: player-input bundle between board buttons, capture block and game controller.
interface button_capture_if;
    import relaxar_pkg::*;
    logic       enable;
    logic [3:0] btn;
    logic       inputed;
    color_t     color;
    logic       busy;
    logic       timeout;
    modport master (output enable, btn, input inputed, color, busy, timeout);
    modport slave  (input enable, btn, output inputed, color, busy, timeout);
endinterface

// File: rtl/button_capture_debounce.sv
// btn_debounce: 2-flop synchroniser, polarity normalisation and stable-count debounce of one button.
module btn_debounce #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic clock,
    input  logic reset_n,
    input  logic raw,
    output logic level,
    output logic quiet
);
    logic [1:0]  sync_q;
    logic        level_q, level_d, pressed, last;
    logic [15:0] cnt_q, cnt_d;
    assign pressed = sync_q[1] ^ BTN_ACTIVE_LOW;
    assign last    = pressed != level_q && cnt_q == DEBOUNCE_CYCLES - 16'd1;
    always_comb begin
        cnt_d   = (pressed == level_q || last) ? '0 : cnt_q + 16'd1;
        level_d = last ? pressed : level_q;
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= {2{BTN_ACTIVE_LOW}};
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], raw};
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end
    assign level = level_q;
    // Quiet also covers the first sync stage so a press already in flight blocks arming.
    assign quiet = !level_q && !pressed && (sync_q[0] == BTN_ACTIVE_LOW);
endmodule

// File: rtl/button_capture.sv
// button_capture: debounces the 4 colour buttons and emits one inputed pulse plus colour per accepted press.
// Optional INPUT_TIMEOUT_EN adds an armed-idle timeout pulse; without it timeout is tied 0.
module button_capture
    import relaxar_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [31:0] TIMEOUT_CYCLES  = 32'd250000000,
    parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic              clock,
    input  logic              reset_n,
    button_capture_if.slave   bus
);
    logic [3:0] level, quiet;
    logic       none, one, tmo_hit, rdy_q;
    cap_state_t state_q, state_d;
    color_t     color_q, color_d;
    for (genvar i = 0; i < 4; i++) begin : g_btn
        btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .BTN_ACTIVE_LOW(BTN_ACTIVE_LOW)) u_db (
            .clock(clock), .reset_n(reset_n), .raw(bus.btn[i]), .level(level[i]), .quiet(quiet[i]));
    end
    assign none = level == 4'd0;
    assign one  = $onehot(level);
`ifdef INPUT_TIMEOUT_EN
    logic [31:0] tmo_q;
    assign tmo_hit = state_q == ARMED && bus.enable && none && tmo_q == TIMEOUT_CYCLES - 32'd1;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) tmo_q <= '0;
        else          tmo_q <= (state_q == ARMED) ? tmo_q + 32'd1 : '0;
    end
`else
    assign tmo_hit = 1'b0;
`endif
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= WAIT_REL;
            color_q <= GREEN;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            color_q <= color_d;
            rdy_q   <= 1'b1;
        end
    end
    // rdy_q holds off arming for one cycle after reset so a button held through reset reaches the synchroniser first.
    always_comb begin
        state_d = state_q;
        color_d = color_q;
        case (state_q)
            WAIT_REL: state_d = (bus.enable && rdy_q && &quiet) ? ARMED : WAIT_REL;
            ARMED: begin
                state_d = !bus.enable ? WAIT_REL : one ? FIRE : !none ? HOLD : tmo_hit ? WAIT_REL : ARMED;
                color_d = (bus.enable && one) ? encode(level) : color_q;
            end
            FIRE:    state_d = HOLD;
            default: state_d = none ? WAIT_REL : HOLD;
        endcase
    end
    always_comb begin
        bus.inputed = state_q == FIRE;
        bus.busy    = state_q != ARMED;
        bus.timeout = tmo_hit;
        bus.color   = color_q;
    end
endmodule

// File: tb/tb_button_capture.sv
// tb_button_capture: randomized press scenarios against an expected-pulse scoreboard (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=20).
module tb_button_capture;
    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       en = 1'b0;
    logic [3:0] press = 4'd0;
    int tests = 0, failed = 0;
    int cyc = 0, pulses = 0, touts = 0, last_pulse_cyc = 0, tout_cyc = 0;
    int exp_q[$];

    button_capture_if bus ();
    assign bus.enable = en;
    assign bus.btn    = ~press;

    button_capture #(.DEBOUNCE_CYCLES(16'd4), .TIMEOUT_CYCLES(32'd20), .BTN_ACTIVE_LOW(1'b1)) dut (
        .clock(clock), .reset_n(reset_n), .bus(bus));

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Each observed pulse must match the oldest press the scoreboard predicted.
    always @(negedge clock) if (reset_n) begin
        if (bus.inputed) begin
            pulses++;
            last_pulse_cyc = cyc;
            check("pulse_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) check("pulse_color", int'(bus.color), exp_q.pop_front());
        end
        if (bus.timeout) begin
            touts++;
            tout_cyc = cyc;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic settle();
        press = 4'd0;
        tick(14);
    endtask

    task automatic two_buttons(output int a, output int b);
        a = $urandom_range(0, 3);
        b = (a + $urandom_range(1, 3)) % 4;
    endtask

    task automatic scen_clean();
        int b = $urandom_range(0, 3), base = pulses, pc;
        exp_q.push_back(b);
        press[b] = 1'b1;
        pc = cyc;
        tick($urandom_range(8, 15));
        check("clean_latency", last_pulse_cyc - pc, 7);
        check("clean_busy_held", int'(bus.busy), 1);
        settle();
        check("clean_count", pulses - base, 1);
        check("clean_busy_idle", int'(bus.busy), 0);
        check("clean_color_kept", int'(bus.color), b);
    endtask

    task automatic scen_bounce();
        int b = $urandom_range(0, 3), base = pulses;
        exp_q.push_back(b);
        repeat ($urandom_range(2, 4)) begin
            press[b] = 1'b1;
            tick($urandom_range(1, 3));
            press[b] = 1'b0;
            tick($urandom_range(1, 3));
        end
        press[b] = 1'b1;
        tick(12);
        settle();
        check("bounce_count", pulses - base, 1);
    endtask

    task automatic scen_dual();
        int a, b, base = pulses, col = int'(bus.color);
        two_buttons(a, b);
        press[a] = 1'b1;
        press[b] = 1'b1;
        tick(12);
        check("dual_count", pulses - base, 0);
        check("dual_busy_held", int'(bus.busy), 1);
        press[a] = 1'b0;
        tick(12);
        check("dual_busy_one_left", int'(bus.busy), 1);
        settle();
        check("dual_busy_idle", int'(bus.busy), 0);
        check("dual_color_kept", int'(bus.color), col);
    endtask

    task automatic scen_overlap();
        int a, b, base = pulses;
        two_buttons(a, b);
        exp_q.push_back(a);
        press[a] = 1'b1;
        tick(10);
        press[b] = 1'b1;
        tick(10);
        settle();
        check("overlap_count", pulses - base, 1);
    endtask

    task automatic scen_disabled();
        int b = $urandom_range(0, 3), base = pulses;
        en = 1'b0;
        tick(2);
        press[b] = 1'b1;
        tick(12);
        check("dis_count", pulses - base, 0);
        en = 1'b1;
        tick(12);
        check("dis_enable_held_count", pulses - base, 0);
        check("dis_busy_held", int'(bus.busy), 1);
        settle();
        check("dis_busy_idle", int'(bus.busy), 0);
        exp_q.push_back(b);
        press[b] = 1'b1;
        tick(10);
        settle();
        check("dis_repress_count", pulses - base, 1);
    endtask

    task automatic scen_reset();
        int b = $urandom_range(0, 3), base, k = 0;
        exp_q.push_back(b);
        press[b] = 1'b1;
        while (!bus.inputed && k < 30) begin
            @(negedge clock);
            k++;
        end
        check("rst_fire_seen", int'(bus.inputed), 1);
        #1 reset_n = 1'b0;
        #1;
        check("rst_inputed", int'(bus.inputed), 0);
        check("rst_color", int'(bus.color), 0);
        check("rst_busy", int'(bus.busy), 1);
        check("rst_queue_empty", exp_q.size(), 0);
        tick(2);
        reset_n = 1'b1;
        base = pulses;
        tick(20);
        check("rst_held_count", pulses - base, 0);
        check("rst_held_busy", int'(bus.busy), 1);
        settle();
        exp_q.push_back(b);
        press[b] = 1'b1;
        tick(10);
        settle();
        check("rst_repress_count", pulses - base, 1);
    endtask

    initial begin
        #2;
        check("reset_inputed", int'(bus.inputed), 0);
        check("reset_color", int'(bus.color), 0);
        check("reset_busy", int'(bus.busy), 1);
        check("reset_timeout", int'(bus.timeout), 0);
        tick(2);
        reset_n = 1'b1;
        en = 1'b1;
        tick(10);
        check("armed_after_reset", int'(bus.busy), 0);
        for (int i = 0; i < 20; i++) begin
            case (i < 5 ? i : $urandom_range(0, 4))
                0: scen_clean();
                1: scen_bounce();
                2: scen_dual();
                3: scen_overlap();
                default: scen_disabled();
            endcase
        end
        scen_reset();
`ifdef INPUT_TIMEOUT_EN
        begin
            int base = touts, c0;
            en = 1'b0;
            tick(3);
            en = 1'b1;
            c0 = cyc;
            tick(25);
            check("tout_count", touts - base, 1);
            check("tout_latency", tout_cyc - c0, 20);
            check("tout_rearmed", int'(bus.busy), 0);
        end
`else
        check("tout_never", touts, 0);
`endif
        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, failed);
        $fatal(1, "watchdog expired");
    end
endmodule
